// File: rtl/req_ack_responder.sv
// Responder side of a single-pulse req/ack handshake: acknowledges each accepted
// req after ACK_DELAY cycles and drops and counts reqs arriving inside the MIN_GAP window.
module req_ack_responder #(
    parameter int unsigned ACK_DELAY = 4,
    parameter int unsigned MIN_GAP   = 8,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    input  logic             err_clr,
    output logic             ack,
    output logic             busy,
    output logic             err_overlap,
    output logic [CNT_W-1:0] req_count,
    output logic [CNT_W-1:0] ack_count,
    output logic [CNT_W-1:0] viol_count
);

    localparam int unsigned TW = $clog2(MIN_GAP) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             ack_q, ack_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] req_cnt_q, req_cnt_d;
    logic [CNT_W-1:0] ack_cnt_q, ack_cnt_d;
    logic [CNT_W-1:0] viol_cnt_q, viol_cnt_d;
    logic             accept_c;
    logic             viol_c;

    // Timer counts cycles since the accepted req; it selects the ack cycle and window end.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        accept_c   = 1'b0;
        viol_c     = 1'b0;
        ack_d      = 1'b0;
        busy_d     = 1'b0;
        err_d      = err_q;
        req_cnt_d  = req_cnt_q;
        ack_cnt_d  = ack_cnt_q;
        viol_cnt_d = viol_cnt_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    accept_c = 1'b1;
                    timer_d  = TW'(1);
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (timer_q == TW'(ACK_DELAY)) begin
                    if (ACK_DELAY == MIN_GAP - 1) begin
                        state_d = IDLE;
                        timer_d = '0;
                    end else begin
                        state_d = HOLD;
                        timer_d = timer_q + TW'(1);
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            HOLD: begin
                if (timer_q == TW'(MIN_GAP - 1)) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase

        viol_c = req && (state_q != IDLE);
        ack_d  = (state_d == WAIT) && (timer_d == TW'(ACK_DELAY));
        busy_d = (state_d != IDLE);

        // A violation in the same cycle as err_clr keeps the flag set.
        if (viol_c) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end

        if (accept_c) req_cnt_d  = req_cnt_q + CNT_W'(1);
        if (ack_d)    ack_cnt_d  = ack_cnt_q + CNT_W'(1);
        if (viol_c)   viol_cnt_d = viol_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            req_cnt_q  <= '0;
            ack_cnt_q  <= '0;
            viol_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            req_cnt_q  <= req_cnt_d;
            ack_cnt_q  <= ack_cnt_d;
            viol_cnt_q <= viol_cnt_d;
        end
    end

    assign ack         = ack_q;
    assign busy        = busy_q;
    assign err_overlap = err_q;
    assign req_count   = req_cnt_q;
    assign ack_count   = ack_cnt_q;
    assign viol_count  = viol_cnt_q;

endmodule

// File: tb/tb_req_ack_responder.sv
// Bench for req_ack_responder: directed req patterns, ack timing checked by a scoreboard monitor.
module tb_req_ack_responder;

    localparam int unsigned ACK_DELAY = 4;
    localparam int unsigned MIN_GAP   = 8;
    localparam int unsigned CNT_W     = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req = 1'b0;
    logic             err_clr = 1'b0;
    logic             ack, busy, err_overlap;
    logic [CNT_W-1:0] req_count, ack_count, viol_count;

    logic             req2 = 1'b0;
    logic             ack2, busy2, err2;
    logic [1:0]       rc2, ac2, vc2;

    int cyc = 0;
    int base = 0;
    int checks = 0;
    int errors = 0;
    int last_acc = -1000;
    int popped = 0;
    int exp_ack_q[$];

    req_ack_responder #(.ACK_DELAY(ACK_DELAY), .MIN_GAP(MIN_GAP), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .err_clr(err_clr),
        .ack(ack), .busy(busy), .err_overlap(err_overlap),
        .req_count(req_count), .ack_count(ack_count), .viol_count(viol_count)
    );

    req_ack_responder #(.ACK_DELAY(ACK_DELAY), .MIN_GAP(MIN_GAP), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .req(req2), .err_clr(1'b0),
        .ack(ack2), .busy(busy2), .err_overlap(err2),
        .req_count(rc2), .ack_count(ac2), .viol_count(vc2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (rel cycle %0d)", name, act, exp, cyc - base);
        end
    endtask

    // Scoreboard monitor: every ack must match the oldest expected ack cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (exp_ack_q.size() > 0 && exp_ack_q[0] < cyc) begin
                checks++;
                errors++;
                $display("FAIL ack_missing actual=none required_cycle=%0d", exp_ack_q[0] - base);
                popped = exp_ack_q.pop_front();
            end
            if (ack) begin
                if (exp_ack_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ack_unexpected actual=1 required=0 (rel cycle %0d)", cyc - base);
                end else begin
                    popped = exp_ack_q.pop_front();
                    check("ack_cycle", cyc - base, popped - base);
                end
            end
        end
    end

    task automatic at(input int rel);
        while (cyc < base + rel) @(negedge clk);
    endtask

    task automatic model_req(input int c);
        if (c - last_acc >= int'(MIN_GAP)) begin
            last_acc = c;
            exp_ack_q.push_back(c + int'(ACK_DELAY));
        end
    endtask

    task automatic drive(input int rel, input logic r, input logic ec);
        at(rel);
        req = r;
        err_clr = ec;
        if (r) model_req(base + rel);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req = 1'b0;
        req2 = 1'b0;
        err_clr = 1'b0;
        exp_ack_q.delete();
        last_acc = -1000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base = cyc;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"}, ack, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err"}, err_overlap, 0);
        check({tag, "_req_count"}, req_count, 0);
        check({tag, "_ack_count"}, ack_count, 0);
        check({tag, "_viol_count"}, viol_count, 0);
    endtask

    initial begin
        #12;
        check_all_zero("reset");

        // Single req at 10: ack at 14, busy 11..17
        do_reset();
        for (int r = 9; r <= 19; r++) begin
            at(r);
            if (r == 10) drive(10, 1'b1, 1'b0);
            if (r == 11) drive(11, 1'b0, 1'b0);
            check("t1_busy", busy, int'(r >= 11 && r <= 17));
        end
        at(20);
        check("t1_req_count", req_count, 1);
        check("t1_ack_count", ack_count, 1);
        check("t1_viol_count", viol_count, 0);

        // Back-to-back reqs exactly MIN_GAP apart
        do_reset();
        drive(10, 1'b1, 1'b0);
        drive(11, 1'b0, 1'b0);
        at(17);
        check("t2_busy_17", busy, 1);
        at(18);
        check("t2_busy_18", busy, 0);
        drive(18, 1'b1, 1'b0);
        drive(19, 1'b0, 1'b0);
        at(25);
        check("t2_err", err_overlap, 0);
        check("t2_viol_count", viol_count, 0);
        check("t2_req_count", req_count, 2);
        check("t2_ack_count", ack_count, 2);

        // Early req at 15 is dropped
        do_reset();
        drive(10, 1'b1, 1'b0);
        drive(11, 1'b0, 1'b0);
        drive(15, 1'b1, 1'b0);
        check("t3_err_15", err_overlap, 0);
        drive(16, 1'b0, 1'b0);
        check("t3_err_16", err_overlap, 1);
        check("t3_viol_count", viol_count, 1);
        at(20);
        check("t3_req_count", req_count, 1);
        check("t3_ack_count", ack_count, 1);

        // err_clr, then set-wins when clear and violation coincide
        drive(20, 1'b0, 1'b1);
        drive(21, 1'b0, 1'b0);
        check("t4_err_cleared", err_overlap, 0);
        drive(30, 1'b1, 1'b0);
        drive(31, 1'b0, 1'b0);
        drive(32, 1'b1, 1'b0);
        drive(33, 1'b0, 1'b0);
        check("t4_err_33", err_overlap, 1);
        drive(35, 1'b1, 1'b1);
        drive(36, 1'b0, 1'b0);
        check("t4_err_set_wins", err_overlap, 1);
        check("t4_viol_count", viol_count, 3);
        drive(37, 1'b0, 1'b1);
        drive(38, 1'b0, 1'b0);
        check("t4_err_38", err_overlap, 0);
        // Held req level: one accept plus one violation per extra cycle
        drive(40, 1'b1, 1'b0);
        drive(41, 1'b1, 1'b0);
        drive(42, 1'b1, 1'b0);
        drive(43, 1'b0, 1'b0);
        check("t4_level_viol", viol_count, 5);
        check("t4_level_req", req_count, 3);
        at(46);
        check("t4_ack_count", ack_count, 3);
        check("t4_err_level", err_overlap, 1);

        // Reset mid-WAIT cancels the pending ack
        do_reset();
        drive(10, 1'b1, 1'b0);
        drive(11, 1'b0, 1'b0);
        at(12);
        rst_n = 1'b0;
        exp_ack_q.delete();
        last_acc = -1000;
        #1;
        check_all_zero("t5_async");
        at(13);
        rst_n = 1'b1;
        at(14);
        check("t5_no_ack_14", ack, 0);
        at(19);
        check("t5_busy_19", busy, 0);
        drive(20, 1'b1, 1'b0);
        drive(21, 1'b0, 1'b0);
        at(26);
        check("t5_req_count", req_count, 1);
        check("t5_ack_count", ack_count, 1);
        check("t5_queue_empty", exp_ack_q.size(), 0);

        // 2-bit counters wrap after four reqs
        do_reset();
        for (int k = 0; k < 5; k++) begin
            at(10 + 8 * k);
            req2 = 1'b1;
            at(11 + 8 * k);
            req2 = 1'b0;
            at(12 + 8 * k);
            check("t6_wait_req_count", rc2, (k + 1) % 4);
            check("t6_wait_ack_count", ac2, k % 4);
            at(15 + 8 * k);
            check("t6_req_count", rc2, (k + 1) % 4);
            check("t6_ack_count", ac2, (k + 1) % 4);
        end
        check("t6_viol_count", vc2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
